// File: rtl/ip4_rtl_arb_pkg.sv
// Shared types and helpers for the IP4 AXI address-channel arbiter.
// Holds the FSM state enum, the counter width and the rotate-priority pick.
package ip4_rtl_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } arb_state_e;

    localparam int IP4_ARB_CNT_W = 4;

    // One-hot of the first set bit of elig at or above ptr, wrapping at n.
    function automatic logic [7:0] rr_onehot(
        input logic [7:0] elig,
        input logic [2:0] ptr,
        input int         n
    );
        logic [7:0] oh;
        logic       found;
        logic [2:0] j;
        oh    = '0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k < n) begin
                j = 3'((int'(ptr) + k) % n);
                if (!found && elig[j]) begin
                    oh[j] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/ip4_rtl_rr_pick.sv
// Combinational round-robin picker.
// Grants the first eligible requester at or above the pointer.
import ip4_rtl_arb_pkg::*;

module ip4_rtl_rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  elig,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    // Rotate-priority one-hot grant, then its binary index.
    always_comb begin
        gnt = N'(rr_onehot(8'(elig), 3'(ptr), N));
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) idx = PW'(i);
        end
        any = |elig;
    end

endmodule

// File: rtl/ip4_rtl_axi_arb.sv
// Round-robin arbiter for the IP4 AXI master address channel.
// Tags addresses with the requester ID, limits outstanding, supports drain.
import ip4_rtl_arb_pkg::*;

module ip4_rtl_axi_arb #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 4,
    parameter int ADDR_W   = 32,
    parameter int LEN_W    = 4,
    parameter int MAX_OUTS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]    req_len,
    input  logic [NUM_REQ-1:0]          req_wr,
    output logic                        m_avalid,
    input  logic                        m_aready,
    output logic [ADDR_W-1:0]           m_aaddr,
    output logic [LEN_W-1:0]            m_alen,
    output logic                        m_awr,
    output logic [ID_W-1:0]             m_aid,
    input  logic                        rsp_valid,
    input  logic [ID_W-1:0]             rsp_id,
    input  logic                        flush_req,
    output logic                        flush_done,
    output logic [NUM_REQ*4-1:0]        outs_cnt,
    output logic                        err
);

    localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int CW = IP4_ARB_CNT_W;

    arb_state_e         state;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      nxt_ptr;
    logic [PW-1:0]      eff_ptr;
    logic [PW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [NUM_REQ-1:0] dec;
    logic [NUM_REQ-1:0] hit_zero;
    logic               pick_any;
    logic               hs;
    logic               can_grant;
    logic               accept;
    logic               all_zero;
    logic               rsp_bad;
    logic [CW-1:0]      cnt [NUM_REQ];
    logic [ADDR_W-1:0]  sel_addr;
    logic [LEN_W-1:0]   sel_len;
    logic               sel_wr;

    // Grant window: idle, or the cycle the held address is taken.
    always_comb begin
        hs        = (state == ST_ISSUE) && m_aready;
        nxt_ptr   = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
        eff_ptr   = hs ? nxt_ptr : rr_ptr;
        can_grant = rst_n && !flush_req && ((state == ST_IDLE) || hs);
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] && (cnt[i] < CW'(MAX_OUTS));
        end
    end

    ip4_rtl_rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .elig (elig),
        .ptr  (eff_ptr),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Accept strobe and payload of the winning requester.
    always_comb begin
        req_ready = can_grant ? pick_gnt : '0;
        accept    = can_grant && pick_any;
        sel_addr  = '0;
        sel_len   = '0;
        sel_wr    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_len  = req_len[i*LEN_W +: LEN_W];
                sel_wr   = req_wr[i];
            end
        end
    end

    // Response decode: legal decrements and protocol violations.
    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            hit_zero[i] = rsp_valid && (32'(rsp_id) == i) && (cnt[i] == '0);
            dec[i]      = rsp_valid && (32'(rsp_id) == i) && (cnt[i] != '0);
            outs_cnt[i*4 +: 4] = 4'(cnt[i]);
            if (cnt[i] != '0) all_zero = 1'b0;
        end
        rsp_bad = (rsp_valid && (32'(rsp_id) >= NUM_REQ)) || (|hit_zero);
    end

    // Outstanding counters and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
            err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && !dec[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (!(req_valid[i] && req_ready[i]) && dec[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
            if (rsp_bad) err <= 1'b1;
        end
    end

    // Arbiter FSM with registered address-channel outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            gnt_idx    <= '0;
            m_avalid   <= 1'b0;
            m_aaddr    <= '0;
            m_alen     <= '0;
            m_awr      <= 1'b0;
            m_aid      <= '0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= (state == ST_DRAIN) && flush_req && all_zero;
            if (accept) begin
                gnt_idx <= pick_idx;
                m_aaddr <= sel_addr;
                m_alen  <= sel_len;
                m_awr   <= sel_wr;
                m_aid   <= ID_W'(pick_idx);
            end
            unique case (state)
                ST_IDLE: begin
                    if (flush_req) begin
                        state <= ST_DRAIN;
                    end else if (accept) begin
                        state    <= ST_ISSUE;
                        m_avalid <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (m_aready) begin
                        rr_ptr <= nxt_ptr;
                        if (flush_req) begin
                            state    <= ST_DRAIN;
                            m_avalid <= 1'b0;
                        end else if (!accept) begin
                            state    <= ST_IDLE;
                            m_avalid <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!flush_req) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ip4_rtl_axi_arb.sv
// Self-checking bench for ip4_rtl_axi_arb (4 requesters, limit 2).
// Table vectors, directed corner sequences and a random run vs. a model.
module tb_ip4_rtl_axi_arb;

    localparam int NR   = 4;
    localparam int MAXO = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_addr;
    logic [15:0]  req_len;
    logic [3:0]   req_wr = '0;
    logic         m_avalid;
    logic         m_aready = 1'b0;
    logic [31:0]  m_aaddr;
    logic [3:0]   m_alen;
    logic         m_awr;
    logic [3:0]   m_aid;
    logic         rsp_valid = 1'b0;
    logic [3:0]   rsp_id = '0;
    logic         flush_req = 1'b0;
    logic         flush_done;
    logic [15:0]  outs_cnt;
    logic         err;

    logic [31:0]  a_addr [NR];
    logic [3:0]   a_len  [NR];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_addr[i*32 +: 32] = a_addr[i];
            req_len[i*4 +: 4]    = a_len[i];
        end
    end

    ip4_rtl_axi_arb #(
        .NUM_REQ  (4),
        .ID_W     (4),
        .ADDR_W   (32),
        .LEN_W    (4),
        .MAX_OUTS (MAXO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_wr     (req_wr),
        .m_avalid   (m_avalid),
        .m_aready   (m_aready),
        .m_aaddr    (m_aaddr),
        .m_alen     (m_alen),
        .m_awr      (m_awr),
        .m_aid      (m_aid),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .outs_cnt   (outs_cnt),
        .err        (err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: what is on the bus, who is owed responses,
    // whose turn it is, and whether a drain is in progress.
    int          mc [NR];
    int          mptr;
    int          mid;
    int          mwin;
    bit          mbusy;
    bit          mdrain;
    bit          merr;
    bit          mdone;
    logic [31:0] maddr;
    logic [3:0]  mlen;
    logic        mwr;
    logic [3:0]  exp_ready;
    logic [3:0]  last_ready;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mc[i] = 0;
        mptr = 0; mid = 0; mbusy = 0; mdrain = 0; merr = 0; mdone = 0;
    endtask

    task automatic model_comb();
        bit ok;
        int p;
        int j;
        mwin = -1;
        ok = rst_n && !flush_req &&
             ((!mbusy && !mdrain) || (mbusy && m_aready));
        p = (mbusy && m_aready) ? (mid + 1) % NR : mptr;
        if (ok) begin
            for (int k = 0; k < NR; k++) begin
                j = (p + k) % NR;
                if (mwin < 0 && req_valid[j] && mc[j] < MAXO) mwin = j;
            end
        end
        exp_ready = (mwin >= 0) ? 4'(1 << mwin) : 4'b0;
    endtask

    task automatic model_seq();
        bit allz;
        bit hs;
        int r;
        if (!rst_n) begin
            model_reset();
            return;
        end
        allz = 1;
        for (int i = 0; i < NR; i++) if (mc[i] != 0) allz = 0;
        r = int'(rsp_id);
        if (rsp_valid) begin
            if (r >= NR) merr = 1;
            else if (mc[r] == 0) merr = 1;
        end
        for (int i = 0; i < NR; i++) begin
            if (mwin == i) mc[i]++;
            if (rsp_valid && r == i && (mc[i] - ((mwin == i) ? 1 : 0)) > 0)
                mc[i]--;
        end
        mdone = mdrain && flush_req && allz;
        hs = mbusy && m_aready;
        if (hs) mptr = (mid + 1) % NR;
        if (mwin >= 0) begin
            mbusy = 1;
            mid   = mwin;
            maddr = a_addr[mwin];
            mlen  = a_len[mwin];
            mwr   = req_wr[mwin];
        end else if (hs) begin
            mbusy  = 0;
            mdrain = flush_req;
        end else if (!mbusy && !mdrain) begin
            mdrain = flush_req;
        end else if (mdrain && !flush_req) begin
            mdrain = 0;
        end
    endtask

    // One clock: check the combinational grant, clock, check registers.
    task automatic tick();
        #1;
        model_comb();
        last_ready = req_ready;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        @(posedge clk);
        model_seq();
        #1;
        chk("m_avalid", 64'(m_avalid), 64'(mbusy));
        if (mbusy) begin
            chk("m_aid", 64'(m_aid), 64'(mid));
            chk("m_payload", {27'b0, m_awr, m_alen, m_aaddr},
                {27'b0, mwr, mlen, maddr});
        end
        for (int i = 0; i < NR; i++)
            chk("outs_cnt", 64'(outs_cnt[i*4 +: 4]), 64'(mc[i]));
        chk("err", 64'(err), 64'(merr));
        chk("flush_done", 64'(flush_done), 64'(mdone));
    endtask

    task automatic drive(input logic [3:0] v, input logic ar,
                         input logic rv, input logic [3:0] rid,
                         input logic fl);
        req_valid = v;
        m_aready  = ar;
        rsp_valid = rv;
        rsp_id    = rid;
        flush_req = fl;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(4'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] valid;
        logic       aready;
        logic [3:0] ready;
        logic       avalid;
        logic [3:0] aid;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4'd0};
        tbl[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 4'd1};
        tbl[2] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 4'd2};
        tbl[3] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 4'd3};
        tbl[4] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4'd0};
        tbl[5] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 4'd1};
        tbl[6] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 4'd2};
        tbl[7] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 4'd3};
        tbl[8] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 4'd0};
        tbl[9] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 4'd0};

        for (int i = 0; i < NR; i++) begin
            a_addr[i] = 32'hA000_0000 + 32'(i);
            a_len[i]  = 4'(i + 1);
        end
        model_reset();
        do_reset();
        chk("reset_outputs", {37'b0, m_avalid, m_aid, flush_done, outs_cnt, err},
            64'd0);

        // Round-robin fairness and outstanding throttle
        for (int t = 0; t < 10; t++) begin
            drive(tbl[t].valid, tbl[t].aready, 1'b0, 4'd0, 1'b0);
            tick();
            chk("rr_ready", 64'(last_ready), 64'(tbl[t].ready));
            chk("rr_avalid", 64'(m_avalid), 64'(tbl[t].avalid));
            if (tbl[t].avalid) chk("rr_aid", 64'(m_aid), 64'(tbl[t].aid));
        end

        // Backpressure: stable payload, then same-cycle reload
        do_reset();
        a_addr[0] = 32'h1000_0000;
        a_addr[1] = 32'h1100_0000;
        drive(4'b0011, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();
        chk("bp_first_ready", 64'(last_ready), 64'(4'b0001));
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_stall_ready", 64'(last_ready), 64'd0);
            chk("bp_stall_addr", 64'(m_aaddr), 64'(32'h1000_0000));
        end
        drive(4'b0011, 1'b1, 1'b0, 4'd0, 1'b0);
        tick();
        chk("bp_reload_ready", 64'(last_ready), 64'(4'b0010));
        chk("bp_next_aid", 64'(m_aid), 64'd1);

        // Outstanding limit on requester 1
        do_reset();
        drive(4'b0010, 1'b1, 1'b0, 4'd0, 1'b0);
        tick();
        chk("lim_issue1", 64'(last_ready), 64'(4'b0010));
        tick();
        chk("lim_issue2", 64'(last_ready), 64'(4'b0010));
        tick();
        chk("lim_block", 64'(last_ready), 64'd0);
        tick();
        chk("lim_block", 64'(last_ready), 64'd0);
        drive(4'b0010, 1'b1, 1'b1, 4'd1, 1'b0);
        tick();
        chk("lim_rsp_cycle", 64'(last_ready), 64'd0);
        chk("lim_cnt_after_rsp", 64'(outs_cnt[7:4]), 64'd1);
        drive(4'b0010, 1'b1, 1'b0, 4'd0, 1'b0);
        tick();
        chk("lim_third", 64'(last_ready), 64'(4'b0010));

        // Simultaneous increment and decrement
        do_reset();
        drive(4'b0100, 1'b1, 1'b0, 4'd0, 1'b0);
        tick();
        drive(4'b0100, 1'b1, 1'b1, 4'd2, 1'b0);
        tick();
        chk("incdec_ready", 64'(last_ready), 64'(4'b0100));
        chk("incdec_cnt", 64'(outs_cnt[11:8]), 64'd1);

        // Flush with three outstanding
        do_reset();
        drive(4'b0111, 1'b1, 1'b0, 4'd0, 1'b0);
        repeat (3) tick();
        drive(4'b1111, 1'b1, 1'b0, 4'd0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("fl_no_grant", 64'(last_ready), 64'd0);
        end
        for (int r = 0; r < 3; r++) begin
            drive(4'b1111, 1'b1, 1'b1, 4'(r), 1'b1);
            tick();
            chk("fl_not_done", 64'(flush_done), 64'd0);
        end
        drive(4'b1111, 1'b1, 1'b0, 4'd0, 1'b1);
        tick();
        chk("fl_done", 64'(flush_done), 64'd1);
        chk("fl_no_grant_done", 64'(last_ready), 64'd0);
        drive(4'b1111, 1'b1, 1'b0, 4'd0, 1'b0);
        tick();
        chk("fl_exit_ready", 64'(last_ready), 64'd0);
        tick();
        chk("fl_resume", 64'(last_ready), 64'(4'b1000));

        // Randomised traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int st;
            int j;
            bit found;
            for (int i = 0; i < NR; i++) begin
                a_addr[i] = $urandom;
                a_len[i]  = 4'($urandom);
            end
            req_wr    = 4'($urandom);
            req_valid = 4'($urandom);
            m_aready  = ($urandom % 4) != 0;
            if ($urandom_range(0, 39) == 0) flush_req = ~flush_req;
            found = 0;
            rsp_id = 4'd0;
            if ($urandom % 3 == 0) begin
                st = int'($urandom % NR);
                for (int k = 0; k < NR; k++) begin
                    j = (st + k) % NR;
                    if (!found && mc[j] > 0) begin
                        found  = 1;
                        rsp_id = 4'(j);
                    end
                end
            end
            rsp_valid = found;
            tick();
        end

        // Protocol errors, then reset while an address is pending
        do_reset();
        drive(4'b0001, 1'b1, 1'b0, 4'd0, 1'b0);
        tick();
        drive(4'b0000, 1'b1, 1'b1, 4'd5, 1'b0);
        tick();
        chk("err_bad_id", 64'(err), 64'd1);
        chk("err_cnt_kept", 64'(outs_cnt), 64'h0001);
        drive(4'b0000, 1'b1, 1'b1, 4'd3, 1'b0);
        tick();
        chk("err_idle_rsp", 64'(err), 64'd1);
        chk("err_cnt_kept2", 64'(outs_cnt), 64'h0001);
        drive(4'b1111, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();
        chk("rst_pre_avalid", 64'(m_avalid), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_outputs",
            {10'b0, m_avalid, m_aaddr, m_alen, m_awr, m_aid, flush_done,
             outs_cnt[7:0], err},
            64'd0);
        chk("rst_mid_cnt_hi", 64'(outs_cnt[15:8]), 64'd0);
        chk("rst_mid_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
